// File: rtl/ctrl_sep_digitos_pkg.sv
// Shared definitions for the binary-to-BCD splitter: state codes, subtract
// constants and the tens digit to one-hot mapping used by the encoder path.
package ctrl_sep_digitos_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CEN  = 2'd1,
      S_DEC  = 2'd2,
      S_OUT  = 2'd3
   } state_e;

   localparam int K_CIEN = 100;
   localparam int K_DIEZ = 10;

   localparam logic [9:0] OH_ZERO = 10'b1000000000;

   // Bit [9-d] set for digit d; out-of-range digits give all zeros.
   function automatic logic [9:0] dec_to_oh(input logic [3:0] d);
      logic [9:0] oh;
      oh = '0;
      for (int i = 0; i < 10; i++) begin
         if (d == 4'(i)) oh[9-i] = 1'b1;
      end
      return oh;
   endfunction

endpackage

// File: rtl/ctrl_sep_digitos_if.sv
// Handshake and result bus between the value source, the splitter and the
// display encode path.
interface ctrl_sep_digitos_if #(
   parameter int W = 8
);
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   cen;
   logic [3:0]   dec;
   logic [3:0]   uni;
   logic [9:0]   dec_oh;
   logic         busy;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_valid, cen, dec, uni, dec_oh, busy
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_valid, cen, dec, uni, dec_oh, busy
   );
endinterface

// File: rtl/ctrl_sep_digitos_resta_paso.sv
// Conditional subtract: diff = a - k when a >= k, otherwise a passes through.
module ctrl_sep_digitos_resta_paso #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] k_i,
   output logic         ge_o,
   output logic [W-1:0] diff_o
);

   assign ge_o   = (a_i >= k_i);
   assign diff_o = ge_o ? (a_i - k_i) : a_i;

endmodule

// File: rtl/ctrl_sep_digitos.sv
// Splits an unsigned W-bit value into hundreds/tens/units by repeated
// subtraction, one conditional subtract per clock, valid/ready on both sides.
module ctrl_sep_digitos
   import ctrl_sep_digitos_pkg::*;
#(
   parameter int W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   ctrl_sep_digitos_if.slave bus_if
);

   // The subtractor is widened to 7 bits so 100 is representable for narrow W.
   localparam int RW = (W < 7) ? 7 : W;

   state_e       state_q, state_d;
   logic [W-1:0] rem_q, rem_d;
   logic [3:0]   cen_q, cen_d;
   logic [3:0]   dec_q, dec_d;
   logic [3:0]   uni_q, uni_d;
   logic [9:0]   oh_q, oh_d;

   logic [RW-1:0] sub_a, sub_k, sub_diff;
   logic          sub_ge;

   assign sub_a = RW'(rem_q);
   assign sub_k = (state_q == S_CEN) ? RW'(K_CIEN) : RW'(K_DIEZ);

   ctrl_sep_digitos_resta_paso #(.W(RW)) u_resta (
      .a_i    (sub_a),
      .k_i    (sub_k),
      .ge_o   (sub_ge),
      .diff_o (sub_diff)
   );

   always_comb begin
      // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
      state_d = state_q;
      rem_d   = rem_q;
      cen_d   = cen_q;
      dec_d   = dec_q;
      uni_d   = uni_q;
      oh_d    = oh_q;

      if (clr_i) begin
         state_d = S_IDLE;
         rem_d   = '0;
         cen_d   = '0;
         dec_d   = '0;
         uni_d   = '0;
         oh_d    = OH_ZERO;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus_if.in_valid) begin
                  rem_d   = bus_if.in_data;
                  cen_d   = '0;
                  dec_d   = '0;
                  oh_d    = OH_ZERO;
                  state_d = S_CEN;
               end
            end
            S_CEN: begin
               if (sub_ge) begin
                  rem_d = sub_diff[W-1:0];
                  cen_d = cen_q + 4'd1;
               end else begin
                  state_d = S_DEC;
               end
            end
            S_DEC: begin
               if (sub_ge) begin
                  rem_d = sub_diff[W-1:0];
                  dec_d = dec_q + 4'd1;
                  oh_d  = dec_to_oh(dec_q + 4'd1);
               end else begin
                  uni_d   = rem_q[3:0];
                  state_d = S_OUT;
               end
            end
            S_OUT: begin
               if (bus_if.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         cen_q   <= '0;
         dec_q   <= '0;
         uni_q   <= '0;
         oh_q    <= OH_ZERO;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cen_q   <= cen_d;
         dec_q   <= dec_d;
         uni_q   <= uni_d;
         oh_q    <= oh_d;
      end
   end

   assign bus_if.in_ready  = (state_q == S_IDLE) && !clr_i;
   assign bus_if.out_valid = (state_q == S_OUT);
   assign bus_if.busy      = (state_q == S_CEN) || (state_q == S_DEC);
   assign bus_if.cen       = cen_q;
   assign bus_if.dec       = dec_q;
   assign bus_if.uni       = uni_q;
   assign bus_if.dec_oh    = oh_q;

endmodule

// File: tb/tb_ctrl_sep_digitos.sv
// Scoreboard bench for ctrl_sep_digitos: directed corner cases plus an
// exhaustive sweep of all 8-bit inputs under random consumer backpressure.
module tb_ctrl_sep_digitos;

   localparam int W = 8;

   typedef struct {
      int v;
      int h;
      int t;
      int u;
      int k;
      int lat;
   } exp_t;

   logic clk;
   logic rst_n;
   logic clr;
   logic dir_rdy;
   logic rand_rdy;
   logic rnd_bit;
   int   cyc;
   int   n_cmp;
   int   n_err;
   exp_t sb[$];

   ctrl_sep_digitos_if #(.W(W)) ifc ();

   ctrl_sep_digitos #(.W(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (clr),
      .bus_if (ifc.slave)
   );

   assign ifc.out_ready = rand_rdy ? rnd_bit : dir_rdy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      rnd_bit = 1'b1;
      forever begin
         @(posedge clk);
         #1 rnd_bit = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
      end
   endtask

   function automatic exp_t model(input int v, input int k);
      exp_t e;
      e.v   = v;
      e.h   = v / 100;
      e.t   = (v % 100) / 10;
      e.u   = v % 10;
      e.k   = k;
      e.lat = e.h + e.t + 2;
      return e;
   endfunction

   // Monitor: pushes on accept, compares every cycle the result is valid, pops on handoff.
   initial begin
      bit   prev_v;
      exp_t e;
      logic [9:0] one;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n || clr) begin
            sb.delete();
            prev_v = 1'b0;
         end else begin
            if (ifc.in_valid && ifc.in_ready) sb.push_back(model(int'(ifc.in_data), cyc + 1));
            if (ifc.out_valid) begin
               if (sb.size() == 0) begin
                  check("unexpected_out", 32'd1, 32'd0);
               end else begin
                  e   = sb[0];
                  one = 10'd1;
                  if (!prev_v) check("latency", 32'(cyc - e.k), 32'(e.lat));
                  check("cen", 32'(ifc.cen), 32'(e.h));
                  check("dec", 32'(ifc.dec), 32'(e.t));
                  check("uni", 32'(ifc.uni), 32'(e.u));
                  check("dec_oh", 32'(ifc.dec_oh), 32'(one << (9 - e.t)));
                  if (ifc.out_ready) sb.pop_front();
               end
            end
            prev_v = ifc.out_valid;
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int v);
      int n;
      ifc.in_data  = W'(v);
      ifc.in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!ifc.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ifc.in_ready) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 ifc.in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      @(negedge clk);
      while (!ifc.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ifc.out_valid) check("out_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((sb.size() != 0 || ifc.out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || ifc.out_valid) check("drain_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_out_valid"}, 32'(ifc.out_valid), 32'd0);
      check({tag, "_busy"}, 32'(ifc.busy), 32'd0);
      check({tag, "_cen"}, 32'(ifc.cen), 32'd0);
      check({tag, "_dec"}, 32'(ifc.dec), 32'd0);
      check({tag, "_uni"}, 32'(ifc.uni), 32'd0);
      check({tag, "_dec_oh"}, 32'(ifc.dec_oh), 32'h200);
   endtask

   initial begin
      cyc          = 0;
      n_cmp        = 0;
      n_err        = 0;
      rst_n        = 1'b0;
      clr          = 1'b0;
      dir_rdy      = 1'b1;
      rand_rdy     = 1'b0;
      ifc.in_data  = '0;
      ifc.in_valid = 1'b0;

      repeat (3) @(posedge clk);
      #1 check_cleared("por");
      rst_n = 1'b1;
      @(negedge clk);
      check("por_in_ready", 32'(ifc.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // 255 = 2/5/5, leaves nonzero digits for the mid-conversion reset below.
      send(255);
      wait_drain();

      // Reset while in S_DEC with IN=87 (tens counter already advanced).
      send(87);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_cleared("rst_mid");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
      check("rst_no_out", 32'(ifc.out_valid), 32'd0);
      @(posedge clk);
      #1;

      send(0);
      wait_drain();
      send(199);
      wait_drain();

      // Backpressure: result must hold and no accept while consumer stalls.
      dir_rdy = 1'b0;
      send(47);
      wait_out();
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
         check("bp_out_valid", 32'(ifc.out_valid), 32'd1);
         @(negedge clk);
      end
      @(posedge clk);
      #1 dir_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_idle_in_ready", 32'(ifc.in_ready), 32'd1);
      check("bp_idle_out_valid", 32'(ifc.out_valid), 32'd0);
      @(posedge clk);
      #1;
      send(10);
      wait_drain();

      // CLR during S_CEN with IN_VALID held.
      send(150);
      clr          = 1'b1;
      ifc.in_data  = W'(150);
      ifc.in_valid = 1'b1;
      @(negedge clk);
      check("clr_in_ready", 32'(ifc.in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_cleared("clr");
      @(posedge clk);
      @(negedge clk);
      check("clr_no_accept", 32'(ifc.busy), 32'd0);
      @(posedge clk);
      #1 clr = 1'b0;
      @(posedge clk);
      #1 ifc.in_valid = 1'b0;
      wait_drain();

      // CLR in the same cycle as the OUT handoff: result dropped.
      dir_rdy = 1'b0;
      send(5);
      wait_out();
      @(posedge clk);
      #1 begin
         clr     = 1'b1;
         dir_rdy = 1'b1;
      end
      @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      check_cleared("clr_out");
      check("clr_out_queue", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;

      // Exhaustive sweep under random OUT_READY.
      rand_rdy = 1'b1;
      for (int v = 0; v < (1 << W); v++) send(v);
      wait_drain();
      rand_rdy = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
